// File: rtl/fetch_stage.sv
// Instruction-fetch front end: program counter, bench-loadable instruction
// memory and the IF/ID pipeline buffer, sequenced by a LOAD/RUN/HALTED FSM.
module fetch_stage #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            INSTR_WIDTH = 16,
    parameter int unsigned            MEM_WORDS   = 64,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]       load_data,
    input  logic                         start,
    input  logic                         if_pc_stop,
    input  logic                         if_id_buffer_hold,
    input  logic                         if_id_buffer_flush,
    input  logic                         if_pc_mux,
    input  logic [ADDR_WIDTH-1:0]        ex_if_branch_location_result,
    input  logic                         ctrl_id_halt,
    output logic [ADDR_WIDTH-1:0]        if_address_from_pc,
    output logic [INSTR_WIDTH-1:0]       id_instruction,
    output logic [ADDR_WIDTH-1:0]        id_pc_next_address,
    output logic                         id_valid,
    output logic                         halted,
    output logic [1:0]                   fetch_state
);

    localparam int unsigned MemAw = $clog2(MEM_WORDS);
    localparam int unsigned IdxW  = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        StLoad   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  npc_q, npc_d;
    logic                   valid_q, valid_d;

    logic [INSTR_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [IdxW-1:0]        word_idx;
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic [ADDR_WIDTH-1:0]  pc_plus2;

    assign word_idx = pc_q[ADDR_WIDTH-1:1];
    assign pc_plus2 = pc_q + ADDR_WIDTH'(2);

    // Program load port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (!reset && state_q == StLoad && load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Combinational fetch; words beyond the array read as a bubble.
    always_comb begin
        fetch_word = NOP_WORD;
        if (word_idx < IdxW'(MEM_WORDS)) begin
            fetch_word = mem_q[word_idx[MemAw-1:0]];
        end
    end

    // Next-state for FSM, PC and IF/ID buffer; defaults give a bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = NOP_WORD;
        npc_d   = '0;
        valid_d = 1'b0;
        case (state_q)
            StLoad: begin
                pc_d = RESET_PC;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Halt beats a redirect: PC stays where it is.
                if (ctrl_id_halt) begin
                    state_d = StHalted;
                end else begin
                    if (if_pc_mux) begin
                        pc_d = {ex_if_branch_location_result[ADDR_WIDTH-1:1], 1'b0};
                    end else if (!if_pc_stop) begin
                        pc_d = pc_plus2;
                    end
                    if (!if_id_buffer_flush) begin
                        if (if_id_buffer_hold) begin
                            instr_d = instr_q;
                            npc_d   = npc_q;
                            valid_d = valid_q;
                        end else begin
                            instr_d = fetch_word;
                            npc_d   = pc_plus2;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StLoad;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign if_address_from_pc = pc_q;
    assign id_instruction     = instr_q;
    assign id_pc_next_address = npc_q;
    assign id_valid           = valid_q;
    assign halted             = (state_q == StHalted);
    assign fetch_state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed program walk plus random control traffic,
// checked through a scoreboard against a behavioural model.
module tb_fetch_stage;

    localparam int MW = 64;

    logic        clock = 1'b0;
    logic        reset, load_en, start, if_pc_stop, if_id_buffer_hold;
    logic        if_id_buffer_flush, if_pc_mux, ctrl_id_halt;
    logic [5:0]  load_addr;
    logic [15:0] load_data, ex_if_branch_location_result;
    logic [15:0] if_address_from_pc, id_instruction, id_pc_next_address;
    logic        id_valid, halted;
    logic [1:0]  fetch_state;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock                        (clock),
        .reset                        (reset),
        .load_en                      (load_en),
        .load_addr                    (load_addr),
        .load_data                    (load_data),
        .start                        (start),
        .if_pc_stop                   (if_pc_stop),
        .if_id_buffer_hold            (if_id_buffer_hold),
        .if_id_buffer_flush           (if_id_buffer_flush),
        .if_pc_mux                    (if_pc_mux),
        .ex_if_branch_location_result (ex_if_branch_location_result),
        .ctrl_id_halt                 (ctrl_id_halt),
        .if_address_from_pc           (if_address_from_pc),
        .id_instruction               (id_instruction),
        .id_pc_next_address           (id_pc_next_address),
        .id_valid                     (id_valid),
        .halted                       (halted),
        .fetch_state                  (fetch_state)
    );

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] npc;
        logic        valid;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    // Reference model: state 0 LOAD, 1 RUN, 2 HALTED.
    logic [15:0] m_mem [MW];
    int          m_st    = 0;
    int          m_pc    = 0;
    int          m_instr = 0;
    int          m_npc   = 0;
    logic        m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    function automatic void model_bubble();
        m_instr = 0;
        m_npc   = 0;
        m_valid = 1'b0;
    endfunction

    // Predict the effect of the coming edge, queue it, then let the edge happen.
    task automatic tick();
        int word;
        if (reset) begin
            m_st = 0;
            m_pc = 0;
            model_bubble();
        end else if (m_st == 0) begin
            if (load_en) m_mem[load_addr] = load_data;
            if (start) m_st = 1;
            m_pc = 0;
            model_bubble();
        end else if (m_st == 1) begin
            word = (m_pc / 2 < MW) ? int'(m_mem[m_pc / 2]) : 0;
            if (ctrl_id_halt) begin
                m_st = 2;
                model_bubble();
            end else begin
                if (if_id_buffer_flush) begin
                    model_bubble();
                end else if (!if_id_buffer_hold) begin
                    m_instr = word;
                    m_npc   = (m_pc + 2) % 65536;
                    m_valid = 1'b1;
                end
                if (if_pc_mux) m_pc = int'(ex_if_branch_location_result) & 'hFFFE;
                else if (!if_pc_stop) m_pc = (m_pc + 2) % 65536;
            end
        end else begin
            model_bubble();
        end
        sb.push_back('{cyc: edge_cnt + 1, pc: 16'(m_pc), instr: 16'(m_instr),
                       npc: 16'(m_npc), valid: m_valid, st: 2'(m_st)});
        @(posedge clock);
        #1;
        reset = 0; load_en = 0; start = 0; if_pc_stop = 0; if_id_buffer_hold = 0;
        if_id_buffer_flush = 0; if_pc_mux = 0; ctrl_id_halt = 0;
    endtask

    // Monitor: count edges and compare every prediction due at this edge.
    always @(posedge clock) begin
        exp_t e;
        edge_cnt++;
        #3;
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            e = sb.pop_front();
            check("pc", if_address_from_pc, e.pc);
            check("id_instruction", id_instruction, e.instr);
            check("id_pc_next_address", id_pc_next_address, e.npc);
            check("id_valid", id_valid, e.valid);
            check("fetch_state", fetch_state, e.st);
            check("halted", halted, e.st == 2'd2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; load_en = 0; start = 0; if_pc_stop = 0; if_id_buffer_hold = 0;
        if_id_buffer_flush = 0; if_pc_mux = 0; ctrl_id_halt = 0;
        load_addr = '0; load_data = '0; ex_if_branch_location_result = '0;
        tick();
        reset = 1; tick();

        // Program: 1111, 2222, 3333, 4444, then random filler.
        for (int i = 0; i < MW; i++) begin
            load_en   = 1;
            load_addr = 6'(i);
            load_data = (i < 4) ? 16'(32'h1111 * (i + 1)) : 16'($urandom);
            tick();
        end
        start = 1; tick();
        tick(); tick();                              // 1111, 2222; PC = 0004
        if_pc_stop = 1; if_id_buffer_hold = 1; tick();
        if_pc_stop = 1; if_id_buffer_hold = 1; tick();
        tick();                                      // 3333, PC = 0006
        if_pc_mux = 1; ex_if_branch_location_result = 16'h0007; if_pc_stop = 1;
        if_id_buffer_flush = 1; if_id_buffer_hold = 1; tick();
        tick();                                      // 4444
        if_pc_mux = 1; ex_if_branch_location_result = 16'h0080; if_id_buffer_flush = 1; tick();
        tick();                                      // out-of-range word, valid
        if_pc_mux = 1; ex_if_branch_location_result = 16'hFFFE; if_id_buffer_flush = 1; tick();
        tick();                                      // PC wraps to 0000
        ctrl_id_halt = 1; if_pc_mux = 1; ex_if_branch_location_result = 16'h0040; tick();
        start = 1; load_en = 1; load_addr = 6'd0; load_data = 16'hBEEF; tick();
        tick();
        reset = 1; tick();
        start = 1; tick();
        tick();                                      // word 0 still 1111
        repeat (4) tick();                           // PC = 000A
        reset = 1; tick();
        start = 1; tick();
        tick();

        // Random control traffic.
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 99) < 2);
            load_en            = ($urandom_range(0, 1) == 1);
            load_addr          = 6'($urandom);
            load_data          = 16'($urandom);
            start              = ($urandom_range(0, 7) == 0);
            if_pc_stop         = ($urandom_range(0, 3) == 0);
            if_id_buffer_hold  = ($urandom_range(0, 3) == 0);
            if_id_buffer_flush = ($urandom_range(0, 7) == 0);
            if_pc_mux          = ($urandom_range(0, 7) == 0);
            ex_if_branch_location_result =
                ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 150));
            ctrl_id_halt       = ($urandom_range(0, 49) == 0);
            tick();
        end
        tick(); tick();
        @(posedge clock);
        #5;
        check("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
